// File: rtl/demux_sched_pkg.sv
// Shared constants, state encoding and error codes for the 1-to-8 demux sequencer.
package demux_sched_pkg;

    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_DISABLED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/demux_sched_if.sv
// Upstream valid/ready stream, channel controls and per-channel offer bus of the demux sequencer.
interface demux_sched_if
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_dest;
    logic              mode;
    logic [N_OUT-1:0]  chan_en;
    logic [SEL_W-1:0]  sel;
    logic [N_OUT-1:0]  out_valid;
    logic [DATA_W-1:0] out_data;
    logic [N_OUT-1:0]  out_ready;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        output in_valid, in_data, in_dest, mode, chan_en, out_ready,
        input  in_ready, sel, out_valid, out_data, err, err_code, busy
    );

    modport slave (
        input  in_valid, in_data, in_dest, mode, chan_en, out_ready,
        output in_ready, sel, out_valid, out_data, err, err_code, busy
    );
endinterface

// File: rtl/demux_sched_1to8_rr_pick8.sv
// Rotating-priority picker: first set mask bit at or above start, wrapping 7 -> 0.
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [N_OUT-1:0] mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] cand;

    // Walk offsets from far to near so the closest enabled channel is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            cand = start + SEL_W'(i);
            if (mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_sched_1to8.sv
// Sequencer for the 1-to-8 demux: round-robin or directed routing, hold until accept, timeout abort.
// Optional transfer/drop statistics counters are built when DEMUX_SCHED_STATS_EN is defined.
module demux_sched_1to8
    import demux_sched_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    demux_sched_if.slave bus
`ifdef DEMUX_SCHED_STATS_EN
    ,
    output logic [15:0] xfer_cnt,
    output logic [15:0] drop_cnt
`endif
);
    localparam logic [31:0] TLIM = (TIMEOUT != 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t            state;
    logic [SEL_W-1:0]  sel_q;
    logic [N_OUT-1:0]  out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              busy_q;
    logic [SEL_W-1:0]  rr_ptr;
    logic [31:0]       timer;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              in_ready_c;
    logic              accept;
    logic              dest_ok;
    logic              go_rr;
    logic              go_dir;
    logic              drop_dis;
    logic              done;
    logic              tmo;

    rr_pick8 u_pick (
        .mask  (bus.chan_en),
        .start (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // in_ready is combinational so a word can be accepted on the first IDLE edge.
    assign in_ready_c = !rst && (state == IDLE) && (bus.mode || (|bus.chan_en));
    assign accept     = bus.in_valid && in_ready_c;
    assign dest_ok    = bus.chan_en[bus.in_dest];
    assign go_rr      = accept && !bus.mode && pick_found;
    assign go_dir     = accept && bus.mode && dest_ok;
    assign drop_dis   = accept && bus.mode && !dest_ok;
    assign done       = (state == SEND) && bus.out_ready[sel_q];
    // A simultaneous handshake beats the timeout.
    assign tmo        = (state == SEND) && !bus.out_ready[sel_q] &&
                        (TIMEOUT != 0) && (timer == TLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_q       <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
            rr_ptr      <= '0;
            timer       <= '0;
        end else begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_data_q <= bus.in_data;
                    end
                    if (go_rr || go_dir) begin
                        sel_q       <= go_rr ? pick_idx : bus.in_dest;
                        out_valid_q <= N_OUT'(1) << (go_rr ? pick_idx : bus.in_dest);
                        busy_q      <= 1'b1;
                        timer       <= '0;
                        state       <= SEND;
                    end else if (drop_dis) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_DISABLED;
                    end
                end
                SEND: begin
                    if (done || tmo) begin
                        out_valid_q <= '0;
                        busy_q      <= 1'b0;
                        rr_ptr      <= sel_q + SEL_W'(1);
                        state       <= IDLE;
                        if (tmo) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = busy_q;

`ifdef DEMUX_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (done) begin
                xfer_cnt <= sat_inc16(xfer_cnt);
            end
            if (drop_dis || tmo) begin
                drop_cnt <= sat_inc16(drop_cnt);
            end
        end
    end
`endif
endmodule

// File: doc/demux_sched_1to8.md
Name: demux_sched_1to8

Overview:
Sequencing controller for the team's 1-to-8 demultiplexer datapath. It accepts a data stream on a valid/ready input and delivers each word to exactly one of eight output channels. Channels are chosen either round-robin over the enabled channels or by an explicit destination field. It drives the 3-bit select, holds the word until the chosen channel accepts it, and aborts on timeout.

Parameters:
DATA_W, 8, width of the routed data word
TIMEOUT, 16, cycles SEND waits for out_ready before abort; 0 = never abort

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_W  upstream word
in_dest  input  3  destination channel (directed mode only)
mode  input  1  0 = round-robin, 1 = directed
chan_en  input  8  per-channel enable mask
sel  output  3  current demux select
out_valid  output  8  one-hot; bit sel set while a word is offered
out_data  output  DATA_W  held word, shared by all channels
out_ready  input  8  per-channel accept
err  output  1  one-cycle pulse on drop or abort
err_code  output  2  01 = disabled destination, 10 = timeout; valid with err
busy  output  1  high in SEND

Behaviour:
- Reset (async assert): state IDLE, sel=0, out_valid=0, out_data=0, err=0, err_code=0, busy=0, rr_ptr=0, timer=0. in_ready=0 while rst is high. Any held word is discarded.
- States: IDLE, SEND. All state changes occur on the clk edge.
- IDLE, in_ready:
  - mode=0: in_ready = |chan_en.
  - mode=1: in_ready = 1.
  - in_ready is combinational from state, mode and chan_en.
- IDLE, accept when in_valid & in_ready:
  - Capture in_data into out_data.
  - mode=0: sel = first set bit of chan_en searching upward from rr_ptr and wrapping 7 to 0. Go to SEND.
  - mode=1 with chan_en[in_dest]=1: sel = in_dest. Go to SEND.
  - mode=1 with chan_en[in_dest]=0: word is dropped. err=1 and err_code=01 next cycle. Stay IDLE. rr_ptr unchanged.
- SEND:
  - out_valid[sel]=1, all other bits 0. busy=1. in_ready=0.
  - sel, out_data and the target are frozen; chan_en and mode changes are ignored until exit.
  - timer increments each cycle in SEND.
- SEND exit on out_ready[sel]=1:
  - Transfer completes on that edge. out_valid clears. Go to IDLE.
  - rr_ptr = sel+1 mod 8, in both modes.
  - out_ready bits other than sel are ignored.
- SEND exit on timeout (TIMEOUT>0 and timer reaches TIMEOUT-1 with out_ready[sel]=0):
  - Word is dropped. err=1, err_code=10. rr_ptr = sel+1. Go to IDLE.
  - If out_ready[sel] rises in that same cycle, the handshake wins and no error is raised.
- Latency and throughput:
  - Word accepted at edge N is offered from cycle N+1.
  - Maximum throughput is one word per 2 cycles, because IDLE is always revisited.
- sel holds its last value in IDLE. The external demux data input is gated by the out_valid bit.

Optional Feature:
DEMUX_SCHED_STATS_EN
- Defined: adds outputs xfer_cnt (16 bits, total completed transfers) and drop_cnt (16 bits, disabled-destination drops plus timeouts).
  - Both saturate at 0xFFFF.
  - Both are cleared by rst.
  - Both update on the same edge as the corresponding event.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package demux_sched_pkg:
  - constants N_OUT=8 and SEL_W=3
  - state enum {IDLE, SEND}
  - err_code constants ERR_NONE=00, ERR_DISABLED=01, ERR_TIMEOUT=10
- One sub-module rr_pick8:
  - purely combinational rotating priority picker
  - inputs: 8-bit mask, 3-bit start
  - outputs: 3-bit index, found flag

Test Plan:
- Reset mid-SEND: accept 0xA5, assert rst during SEND -> out_valid=0, sel=0, busy=0 immediately; after release next accept goes to channel 0.
- Round-robin: mode=0, chan_en=0xFF, out_ready=0xFF, send 10 words -> sel sequence 0,1,2,...,7,0,1; one word per 2 cycles; out_data matches each word.
- Masked RR with wrap: chan_en=0x81, rr_ptr=1 -> sel=7, then 0, then 7. chan_en=0x00 -> in_ready=0 and no accept.
- Directed disabled: mode=1, chan_en=0xFB, in_dest=2, in_data=0x3C -> no out_valid, err=1 with err_code=01 for exactly one cycle, state stays IDLE.
- Timeout: TIMEOUT=16, out_ready=0 -> out_valid high exactly 16 cycles, then err_code=10, busy=0. Repeat with out_ready[sel] asserted on cycle 16 -> transfer completes, no err.
- Stats (macro defined): 5 completed transfers, 1 disabled-destination drop, 1 timeout -> xfer_cnt=5, drop_cnt=2. Preload near 0xFFFF and confirm saturation.
